key_menu_ctrl: RTL and testbench



---
 rtl/key_menu_ctrl_if.sv | 26 ++
 rtl/key_menu_ctrl.sv | 223 ++++++++++++++++++++++
 tb/tb_key_menu_ctrl.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/key_menu_ctrl_if.sv
// Key-scanner-to-menu-controller bundle: raw keys and timebase in, mode/field/strobes out.
// The slave modport is the controller side.
interface key_menu_ctrl_if #(
  parameter int KEY_W   = 8,
  parameter int FIELD_W = 3
);
  logic               TICK;
  logic [KEY_W-1:0]   KEY;
  logic               TIME_FORMAT;
  logic [1:0]         MODE;
  logic [FIELD_W-1:0] FIELD;
  logic               UP;
  logic               DOWN;
  logic               COMMIT;
  logic               ABORT;

  modport master (
    output TICK, KEY,
    input  TIME_FORMAT, MODE, FIELD, UP, DOWN, COMMIT, ABORT
  );

  modport slave (
    input  TICK, KEY,
    output TIME_FORMAT, MODE, FIELD, UP, DOWN, COMMIT, ABORT
  );
endinterface

// File: rtl/key_menu_ctrl.sv
// Alarm-clock menu/key controller: 2-FF key sync, press decode, mode/field FSM; 3 CLK key-to-output.
// Hold-to-repeat of UP/DOWN in edit states is built only when KEY_AUTOREPEAT_EN is defined.
module key_menu_ctrl #(
  parameter int KEY_W      = 8,
  parameter int FIELD_N    = 7,
  parameter int FIELD_W    = 3,
  parameter int SKIP_FIELD = 4,
  parameter int TIMEOUT    = 1000,
  parameter int RPT_DLY    = 50,
  parameter int RPT_PER    = 10
) (
  input  logic CLK,
  input  logic RESETN,
  key_menu_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    VIEW_TIME  = 2'b00,
    EDIT_TIME  = 2'b01,
    VIEW_ALARM = 2'b10,
    EDIT_ALARM = 2'b11
  } mode_e;

  typedef enum logic [2:0] {
    K_NONE, K_MENU, K_SET, K_CANCEL, K_UP, K_DOWN, K_MULTI
  } key_e;

  localparam int TO_W = $clog2(TIMEOUT + 1);

  logic [KEY_W-1:0]   sync1_q, sync1_d, sync2_q, sync2_d;
  logic [4:0]         key5;
  key_e               code, code_prev_q, code_prev_d;
  logic               press;
  mode_e              mode_q, mode_d;
  logic [FIELD_W-1:0] field_q, field_d;
  logic               tf_q, tf_d;
  logic               up_q, up_d, down_q, down_d;
  logic               commit_q, commit_d, abort_q, abort_d;
  logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
  logic               rpt_fire;
  logic               rpt_is_up;
  logic               unused_ok;

  assign unused_ok = ^{sync2_q, 32'(RPT_DLY), 32'(RPT_PER)};

  function automatic logic [FIELD_W-1:0] next_field(input logic [FIELD_W-1:0] f,
                                                    input logic fmt12);
    logic [FIELD_W-1:0] n;
    n = (f >= FIELD_W'(FIELD_N)) ? FIELD_W'(1) : f + FIELD_W'(1);
    // The meridian field has no meaning in 24 h format, so step over it.
    if (!fmt12 && (n == FIELD_W'(SKIP_FIELD)))
      n = (n >= FIELD_W'(FIELD_N)) ? FIELD_W'(1) : n + FIELD_W'(1);
    return n;
  endfunction

  assign sync1_d     = bus.KEY;
  assign sync2_d     = sync1_q;
  assign key5        = sync2_q[7:3];
  assign code_prev_d = code;

  always_comb begin
    code = K_NONE;
    case (key5)
      5'b00000: code = K_NONE;
      5'b10000: code = K_MENU;
      5'b01000: code = K_SET;
      5'b00100: code = K_CANCEL;
      5'b00010: code = K_UP;
      5'b00001: code = K_DOWN;
      default:  code = K_MULTI;
    endcase
  end

  // Only a clean transition from "nothing held" to a single key counts.
  assign press = (code_prev_q == K_NONE) && (code != K_NONE) && (code != K_MULTI);

`ifdef KEY_AUTOREPEAT_EN
  localparam int RPT_MAX = (RPT_DLY > RPT_PER) ? RPT_DLY : RPT_PER;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);

  logic             rpt_act_q, rpt_act_d, rpt_up_q, rpt_up_d, rpt_first_q, rpt_first_d;
  logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;

  always_comb begin
    rpt_act_d   = rpt_act_q;
    rpt_up_d    = rpt_up_q;
    rpt_first_d = rpt_first_q;
    rpt_cnt_d   = rpt_cnt_q;
    rpt_fire    = 1'b0;
    if (press && mode_q[0] && ((code == K_UP) || (code == K_DOWN))) begin
      rpt_act_d   = 1'b1;
      rpt_up_d    = (code == K_UP);
      rpt_first_d = 1'b1;
      rpt_cnt_d   = '0;
    end else if (rpt_act_q && (!mode_q[0] || (code != (rpt_up_q ? K_UP : K_DOWN)))) begin
      rpt_act_d = 1'b0;
    end else if (rpt_act_q && bus.TICK) begin
      if (rpt_cnt_q == (rpt_first_q ? RPT_W'(RPT_DLY - 1) : RPT_W'(RPT_PER - 1))) begin
        rpt_fire    = 1'b1;
        rpt_first_d = 1'b0;
        rpt_cnt_d   = '0;
      end else begin
        rpt_cnt_d = rpt_cnt_q + RPT_W'(1);
      end
    end
  end

  assign rpt_is_up = rpt_up_q;

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      rpt_act_q   <= 1'b0;
      rpt_up_q    <= 1'b0;
      rpt_first_q <= 1'b0;
      rpt_cnt_q   <= '0;
    end else begin
      rpt_act_q   <= rpt_act_d;
      rpt_up_q    <= rpt_up_d;
      rpt_first_q <= rpt_first_d;
      rpt_cnt_q   <= rpt_cnt_d;
    end
  end
`else
  assign rpt_fire  = 1'b0;
  assign rpt_is_up = 1'b0;
`endif

  always_comb begin
    mode_d   = mode_q;
    field_d  = field_q;
    tf_d     = tf_q;
    up_d     = 1'b0;
    down_d   = 1'b0;
    commit_d = 1'b0;
    abort_d  = 1'b0;
    to_cnt_d = to_cnt_q;
    if (press) begin
      to_cnt_d = '0;
      case (mode_q)
        VIEW_TIME: begin
          case (code)
            K_MENU:   mode_d = VIEW_ALARM;
            K_SET:    begin mode_d = EDIT_TIME; field_d = FIELD_W'(1); end
            K_CANCEL: tf_d = ~tf_q;
            default:  ;
          endcase
        end
        VIEW_ALARM: begin
          case (code)
            K_MENU:   mode_d = VIEW_TIME;
            K_SET:    begin mode_d = EDIT_ALARM; field_d = FIELD_W'(1); end
            K_CANCEL: mode_d = VIEW_TIME;
            default:  ;
          endcase
        end
        default: begin
          case (code)
            K_MENU:   field_d = next_field(field_q, tf_q);
            K_SET:    begin commit_d = 1'b1; field_d = '0; mode_d = mode_e'({mode_q[1], 1'b0}); end
            K_CANCEL: begin abort_d = 1'b1; field_d = '0; mode_d = mode_e'({mode_q[1], 1'b0}); end
            K_UP:     up_d = 1'b1;
            K_DOWN:   down_d = 1'b1;
            default:  ;
          endcase
        end
      endcase
    end else if (mode_q[0]) begin
      if (rpt_fire) begin
        up_d     = rpt_is_up;
        down_d   = ~rpt_is_up;
        to_cnt_d = '0;
      end else if (bus.TICK) begin
        if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
          abort_d  = 1'b1;
          field_d  = '0;
          mode_d   = mode_e'({mode_q[1], 1'b0});
          to_cnt_d = '0;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
    end else begin
      to_cnt_d = '0;
    end
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      code_prev_q <= K_NONE;
      mode_q      <= VIEW_TIME;
      field_q     <= '0;
      tf_q        <= 1'b0;
      up_q        <= 1'b0;
      down_q      <= 1'b0;
      commit_q    <= 1'b0;
      abort_q     <= 1'b0;
      to_cnt_q    <= '0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      code_prev_q <= code_prev_d;
      mode_q      <= mode_d;
      field_q     <= field_d;
      tf_q        <= tf_d;
      up_q        <= up_d;
      down_q      <= down_d;
      commit_q    <= commit_d;
      abort_q     <= abort_d;
      to_cnt_q    <= to_cnt_d;
    end
  end

  assign bus.TIME_FORMAT = tf_q;
  assign bus.MODE        = mode_q;
  assign bus.FIELD       = field_q;
  assign bus.UP          = up_q;
  assign bus.DOWN        = down_q;
  assign bus.COMMIT      = commit_q;
  assign bus.ABORT       = abort_q;

endmodule

// File: tb/tb_key_menu_ctrl.sv
// Bench for key_menu_ctrl: directed walk of the menu flows plus random key traffic
// checked every cycle against a press-event level reference model.
module tb_key_menu_ctrl;
  localparam int KEY_W = 8, FIELD_N = 7, FIELD_W = 3, SKIP_FIELD = 4;
  localparam int TIMEOUT = 1000, RPT_DLY = 50, RPT_PER = 10;
  localparam logic [7:0] KM = 8'h80, KS = 8'h40, KC = 8'h20, KU = 8'h10, KD = 8'h08, K0 = 8'h00;

  logic CLK = 1'b0;
  logic RESETN = 1'b0;
  always #5 CLK = ~CLK;

  key_menu_ctrl_if #(.KEY_W(KEY_W), .FIELD_W(FIELD_W)) bus ();

  key_menu_ctrl #(
    .KEY_W(KEY_W), .FIELD_N(FIELD_N), .FIELD_W(FIELD_W), .SKIP_FIELD(SKIP_FIELD),
    .TIMEOUT(TIMEOUT), .RPT_DLY(RPT_DLY), .RPT_PER(RPT_PER)
  ) dut (
    .CLK(CLK),
    .RESETN(RESETN),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: keys as seen two clocks late, press events, menu rules.
  logic [7:0] k1, k2;
  int m_prev, m_mode, m_field, m_tf, m_to, m_held, m_rt;
  bit e_up, e_down, e_commit, e_abort;
  int o_up, o_down, o_commit, o_abort;

  function automatic int kcode(input logic [7:0] k);
    int n, c;
    n = 0; c = 0;
    for (int b = 7; b >= 3; b--)
      if (k[b]) begin n++; c = 8 - b; end
    if (n == 0) return 0;
    if (n > 1) return 7;
    return c;  // 1 MENU, 2 SET, 3 CANCEL, 4 UP, 5 DOWN
  endfunction

  function automatic int nf(input int f, input int tf);
    int n;
    n = (f >= FIELD_N) ? 1 : f + 1;
    if (tf == 0 && n == SKIP_FIELD) n = (n >= FIELD_N) ? 1 : n + 1;
    return n;
  endfunction

  task automatic model_reset();
    k1 = '0; k2 = '0;
    m_prev = 0; m_mode = 0; m_field = 0; m_tf = 0; m_to = 0; m_held = 0; m_rt = 0;
    e_up = 0; e_down = 0; e_commit = 0; e_abort = 0;
  endtask

  task automatic model_step(input logic [7:0] key, input logic tick);
    logic [7:0] cur;
    int code;
    bit ev, edit, fire;
    cur = k2; k2 = k1; k1 = key;
    code = kcode(cur);
    ev = (m_prev == 0) && (code >= 1) && (code <= 5);
    m_prev = code;
    e_up = 0; e_down = 0; e_commit = 0; e_abort = 0;
    fire = 0;
    edit = (m_mode == 1) || (m_mode == 3);
`ifdef KEY_AUTOREPEAT_EN
    if (ev && edit && (code == 4 || code == 5)) begin
      m_held = code; m_rt = 0;
    end else if (m_held != 0 && (code != m_held || !edit)) begin
      m_held = 0;
    end else if (m_held != 0 && tick) begin
      m_rt++;
      if (m_rt == RPT_DLY || (m_rt > RPT_DLY && (m_rt - RPT_DLY) % RPT_PER == 0)) fire = 1;
    end
`endif
    if (ev) begin
      m_to = 0;
      if (m_mode == 0) begin
        if (code == 1) m_mode = 2;
        else if (code == 2) begin m_mode = 1; m_field = 1; end
        else if (code == 3) m_tf = 1 - m_tf;
      end else if (m_mode == 2) begin
        if (code == 1) m_mode = 0;
        else if (code == 2) begin m_mode = 3; m_field = 1; end
        else if (code == 3) m_mode = 0;
      end else begin
        if (code == 1) m_field = nf(m_field, m_tf);
        else if (code == 2) begin e_commit = 1; m_field = 0; m_mode = m_mode - 1; end
        else if (code == 3) begin e_abort = 1; m_field = 0; m_mode = m_mode - 1; end
        else if (code == 4) e_up = 1;
        else e_down = 1;
      end
    end else if (edit) begin
      if (fire) begin
        if (m_held == 4) e_up = 1; else e_down = 1;
        m_to = 0;
      end else if (tick) begin
        m_to++;
        if (m_to == TIMEOUT) begin
          e_abort = 1; m_field = 0; m_mode = m_mode - 1; m_to = 0;
        end
      end
    end
  endtask

  function automatic logic [31:0] dut_vec();
    return 32'({bus.TIME_FORMAT, bus.MODE, bus.FIELD, bus.UP, bus.DOWN, bus.COMMIT, bus.ABORT});
  endfunction

  function automatic logic [31:0] model_vec();
    logic [1:0] md;
    logic [2:0] fd;
    md = 2'(m_mode);
    fd = 3'(m_field);
    return 32'({m_tf[0], md, fd, e_up, e_down, e_commit, e_abort});
  endfunction

  task automatic step(input logic [7:0] key, input logic tick);
    bus.KEY = key;
    bus.TICK = tick;
    model_step(key, tick);
    @(negedge CLK);
    chk("outputs", dut_vec(), model_vec());
    o_up += int'(bus.UP); o_down += int'(bus.DOWN);
    o_commit += int'(bus.COMMIT); o_abort += int'(bus.ABORT);
  endtask

  task automatic press(input logic [7:0] key);
    repeat (3) step(key, 1'b0);
    repeat (3) step(K0, 1'b0);
  endtask

  task automatic do_reset(input string tag);
    bus.KEY = K0;
    bus.TICK = 1'b0;
    RESETN = 1'b0;
    model_reset();
    #1;
    chk({tag, "_vec"}, dut_vec(), 32'h0);
    @(negedge CLK);
    RESETN = 1'b1;
  endtask

  task automatic clr_cnt();
    o_up = 0; o_down = 0; o_commit = 0; o_abort = 0;
  endtask

  int exp_f1[7] = '{2, 3, 5, 6, 7, 1, 2};
  int rpt_at[$];
  int sel, hold;
  logic [7:0] rk;

  initial begin
    clr_cnt();
    model_reset();
    bus.KEY = K0;
    bus.TICK = 1'b0;
    @(negedge CLK);
    do_reset("reset");

    // SET from VIEW_TIME: 3-clock latency, then MENU stepping with skip
    step(KS, 1'b0); chk("lat1_mode", 32'(bus.MODE), 0);
    step(KS, 1'b0); chk("lat2_mode", 32'(bus.MODE), 0);
    step(KS, 1'b0); chk("lat3_mode", 32'(bus.MODE), 1); chk("lat3_field", 32'(bus.FIELD), 1);
    repeat (3) step(K0, 1'b0);
    for (int i = 0; i < 7; i++) begin
      press(KM);
      chk($sformatf("skip_field%0d", i), 32'(bus.FIELD), 32'(exp_f1[i]));
    end
    clr_cnt();
    press(KC);
    chk("cancel_abort", 32'(o_abort), 1); chk("cancel_mode", 32'(bus.MODE), 0);

    // 12 h format: field 4 reachable, SET commits
    press(KC); chk("tf_toggle", 32'(bus.TIME_FORMAT), 1); chk("tf_mode", 32'(bus.MODE), 0);
    press(KS);
    for (int i = 2; i <= 4; i++) begin
      press(KM);
      chk($sformatf("fmt12_field%0d", i), 32'(bus.FIELD), 32'(i));
    end
    clr_cnt();
    press(KS);
    chk("commit_cnt", 32'(o_commit), 1); chk("commit_mode", 32'(bus.MODE), 0);
    chk("commit_field", 32'(bus.FIELD), 0);

    // Alarm edit, UP then DOWN strobes
    press(KM); chk("view_alarm", 32'(bus.MODE), 2);
    press(KS); chk("edit_alarm", 32'(bus.MODE), 3); chk("edit_alarm_f", 32'(bus.FIELD), 1);
    clr_cnt();
    for (int d = 0; d < 2; d++) begin
      rk = (d == 0) ? KU : KD;
      step(rk, 1'b0); step(rk, 1'b0);
      chk("ud_early", 32'({bus.UP, bus.DOWN}), 0);
      step(rk, 1'b0);
      chk("ud_strobe", 32'({bus.UP, bus.DOWN}), (d == 0) ? 2 : 1);
      chk("ud_field", 32'(bus.FIELD), 1);
      step(rk, 1'b0);
      chk("ud_one_clk", 32'({bus.UP, bus.DOWN}), 0);
      repeat (3) step(K0, 1'b0);
    end
    chk("up_cnt", 32'(o_up), 1); chk("down_cnt", 32'(o_down), 1);

    // Both keys together: nothing happens
    clr_cnt();
    repeat (6) step(KU | KD, 1'b0);
    repeat (3) step(K0, 1'b0);
    chk("multi_strobes", 32'(o_up + o_down), 0);
    chk("multi_mode", 32'(bus.MODE), 3); chk("multi_field", 32'(bus.FIELD), 1);

    // Reset mid edit: immediate, no abort
    clr_cnt();
    do_reset("midreset");
    chk("midreset_abort", 32'(o_abort), 0);

    // Inactivity timeout, and a press at tick 999 restarting it
    press(KS);
    clr_cnt();
    repeat (TIMEOUT - 1) step(K0, 1'b1);
    chk("to_999_abort", 32'(o_abort), 0); chk("to_999_mode", 32'(bus.MODE), 1);
    step(K0, 1'b1);
    chk("to_1000_abort", 32'(bus.ABORT), 1); chk("to_1000_mode", 32'(bus.MODE), 0);
    press(KS);
    clr_cnt();
    repeat (TIMEOUT - 1) step(K0, 1'b1);
    press(KU);
    repeat (TIMEOUT - 1) step(K0, 1'b1);
    chk("restart_abort", 32'(o_abort), 0); chk("restart_mode", 32'(bus.MODE), 1);
    step(K0, 1'b1);
    chk("restart_to", 32'(bus.ABORT), 1);

    // Hold UP for 80 ticks
    press(KS);
    clr_cnt();
    repeat (4) step(KU, 1'b0);
    chk("hold_first", 32'(o_up), 1);
    for (int t = 1; t <= 80; t++) begin
      step(KU, 1'b1);
      if (bus.UP) rpt_at.push_back(t);
      step(KU, 1'b0);
    end
`ifdef KEY_AUTOREPEAT_EN
    chk("rpt_count", 32'(rpt_at.size()), 4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("rpt_tick%0d", i), (i < rpt_at.size()) ? 32'(rpt_at[i]) : 32'hFFFF,
          32'(RPT_DLY + i * RPT_PER));
`else
    chk("rpt_count", 32'(rpt_at.size()), 0);
`endif
    clr_cnt();
    repeat (3) step(K0, 1'b0);
    repeat (40) step(K0, 1'b1);
    chk("after_release", 32'(o_up), 0);

    // Random traffic against the model
    for (int it = 0; it < 1500; it++) begin
      sel = $urandom_range(0, 99);
      hold = $urandom_range(1, 6);
      if (sel == 0) begin
        do_reset("rnd_reset");
      end else if (sel == 1) begin
        repeat (TIMEOUT + 5) step(K0, 1'b1);
      end else begin
        case (sel % 10)
          0, 1:    rk = K0;
          8:       rk = 8'(KU | KD) | 8'($urandom_range(0, 7));
          9:       rk = 8'($urandom_range(0, 255));
          default: rk = 8'h80 >> $urandom_range(0, 4);
        endcase
        repeat (hold) step(rk, 1'($urandom_range(0, 3) == 0));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
